// File: rtl/ace_snoop_responder_if.sv
// ace_snoop_responder_if
// Groups the three ACE snoop channels (AC request, CR response, CD data).
//   master modport : the snoop responder (accepts AC, drives CR and CD)
//   slave modport  : the snoop issuer (drives AC, accepts CR and CD)
interface ace_snoop_responder_if #(
    parameter int ADDR_WIDTH       = 64,
    parameter int SNOOP_DATA_WIDTH = 128
) ();
    logic                        ACVALID;
    logic                        ACREADY;
    logic [ADDR_WIDTH-1:0]       ACADDR;
    logic [3:0]                  ACSNOOP;
    logic [2:0]                  ACPROT;
    logic                        CRVALID;
    logic                        CRREADY;
    logic [4:0]                  CRRESP;
    logic                        CDVALID;
    logic                        CDREADY;
    logic [SNOOP_DATA_WIDTH-1:0] CDDATA;
    logic                        CDLAST;

    modport master (
        input  ACVALID, ACADDR, ACSNOOP, ACPROT, CRREADY, CDREADY,
        output ACREADY, CRVALID, CRRESP, CDVALID, CDDATA, CDLAST
    );

    modport slave (
        output ACVALID, ACADDR, ACSNOOP, ACPROT, CRREADY, CDREADY,
        input  ACREADY, CRVALID, CRRESP, CDVALID, CDDATA, CDLAST
    );
endinterface

// File: rtl/ace_snoop_responder.sv
// ace_snoop_responder
// Master-side ACE snoop responder backed by a small fully-associative
// line-state table that is preloaded through a fill port.
// Ports:
//   ACLK        clock, rising edge
//   ARESET      asynchronous active-high reset; also clears the table
//   snp         AC/CR/CD snoop channels (master modport)
//   fill_*      table write port (index, tag, valid, dirty, shared, seed)
//   hit_count   saturating count of snoop hits
module ace_snoop_responder #(
    parameter  int ADDR_WIDTH       = 64,
    parameter  int SNOOP_DATA_WIDTH = 128,
    parameter  int CACHE_LINE_SIZE  = 6,
    parameter  int DEPTH            = 4,
    localparam int IDX_W            = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int TAG_W            = ADDR_WIDTH - CACHE_LINE_SIZE
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    ace_snoop_responder_if.master     snp,
    input  logic                      fill_valid,
    input  logic [IDX_W-1:0]          fill_index,
    input  logic [TAG_W-1:0]          fill_tag,
    input  logic                      fill_en,
    input  logic                      fill_dirty,
    input  logic                      fill_shared,
    input  logic [31:0]               fill_seed,
    output logic [15:0]               hit_count
);
    localparam int WORDS       = SNOOP_DATA_WIDTH / 32;
    localparam int BEAT_BYTES  = SNOOP_DATA_WIDTH / 8;
    localparam int LINE_BYTES  = 1 << CACHE_LINE_SIZE;
    localparam int NB          = (LINE_BYTES / BEAT_BYTES > 0) ? LINE_BYTES / BEAT_BYTES : 1;
    localparam int BEAT_W      = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP} state_t;
    typedef enum logic [1:0] {ACT_NONE, ACT_SHARE, ACT_CLEAN, ACT_INVAL} act_t;

    state_t             state_reg;
    logic [TAG_W-1:0]   ac_tag_reg;
    logic [3:0]         ac_snoop_reg;
    logic [31:0]        seed_lat_reg;
    logic [BEAT_W-1:0]  beat_reg;

    logic               valid_reg  [DEPTH];
    logic               dirty_reg  [DEPTH];
    logic               shared_reg [DEPTH];
    logic [TAG_W-1:0]   tag_reg    [DEPTH];
    logic [31:0]        seed_reg   [DEPTH];

    logic [DEPTH-1:0]   match;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               snoop_hit;
    logic [4:0]         resp_next;
    act_t               act_next;
    logic               cr_busy;
    logic               cd_busy;

    // Address offset bits and protection are not needed for a line lookup.
    logic unused_ok;
    assign unused_ok = ^{snp.ACPROT, snp.ACADDR[CACHE_LINE_SIZE-1:0]};

    function automatic logic [SNOOP_DATA_WIDTH-1:0] beat_data(input logic [31:0] seed,
                                                               input logic [BEAT_W-1:0] k);
        logic [31:0] w;
        w = seed + 32'(k);
        return {WORDS{w}};
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_reg[gi] && (tag_reg[gi] == ac_tag_reg);
        end
    endgenerate

    // Lowest matching index wins: scan downward so the last assignment is the lowest.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Response bits {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
    // Only recognised opcodes count as hits; others behave like a miss.
    always_comb begin
        logic d, s, known;
        d         = dirty_reg[hit_idx];
        s         = shared_reg[hit_idx];
        known     = 1'b1;
        resp_next = '0;
        act_next  = ACT_NONE;
        case (ac_snoop_reg)
            4'b0000: resp_next = {!s, 1'b1, 1'b0, 1'b0, 1'b1};
            4'b0001, 4'b0010, 4'b0011: begin
                resp_next = {!s, 1'b1, d, 1'b0, 1'b1};
                act_next  = ACT_SHARE;
            end
            4'b0111: begin
                resp_next = {!s, 1'b0, d, 1'b0, 1'b1};
                act_next  = ACT_INVAL;
            end
            4'b1001: begin
                resp_next = {!s, 1'b0, d, 1'b0, d};
                act_next  = ACT_INVAL;
            end
            4'b1000: begin
                resp_next = {!s, 1'b1, d, 1'b0, d};
                act_next  = ACT_CLEAN;
            end
            4'b1101: begin
                resp_next = {!s, 4'b0000};
                act_next  = ACT_INVAL;
            end
            default: known = 1'b0;
        endcase
        snoop_hit = hit && known;
        if (!snoop_hit) begin
            resp_next = '0;
            act_next  = ACT_NONE;
        end
    end

    // A channel is still busy unless its final handshake happens this edge.
    assign cr_busy = snp.CRVALID && !snp.CRREADY;
    assign cd_busy = snp.CDVALID && !(snp.CDREADY && snp.CDLAST);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg    <= S_IDLE;
            ac_tag_reg   <= '0;
            ac_snoop_reg <= '0;
            seed_lat_reg <= '0;
            beat_reg     <= '0;
            hit_count    <= '0;
            snp.ACREADY  <= 1'b0;
            snp.CRVALID  <= 1'b0;
            snp.CRRESP   <= '0;
            snp.CDVALID  <= 1'b0;
            snp.CDDATA   <= '0;
            snp.CDLAST   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_reg[i]  <= 1'b0;
                dirty_reg[i]  <= 1'b0;
                shared_reg[i] <= 1'b0;
                tag_reg[i]    <= '0;
                seed_reg[i]   <= '0;
            end
        end else begin
            case (state_reg)
                S_IDLE: begin
                    snp.ACREADY <= 1'b1;
                    if (snp.ACREADY && snp.ACVALID) begin
                        snp.ACREADY  <= 1'b0;
                        ac_tag_reg   <= snp.ACADDR[ADDR_WIDTH-1:CACHE_LINE_SIZE];
                        ac_snoop_reg <= snp.ACSNOOP;
                        state_reg    <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    snp.CRVALID <= 1'b1;
                    snp.CRRESP  <= resp_next;
                    if (snoop_hit && hit_count != 16'hFFFF) begin
                        hit_count <= hit_count + 16'd1;
                    end
                    case (act_next)
                        ACT_SHARE: begin
                            shared_reg[hit_idx] <= 1'b1;
                            dirty_reg[hit_idx]  <= 1'b0;
                        end
                        ACT_CLEAN: dirty_reg[hit_idx] <= 1'b0;
                        ACT_INVAL: valid_reg[hit_idx] <= 1'b0;
                        default: ;
                    endcase
                    if (resp_next[0]) begin
                        snp.CDVALID  <= 1'b1;
                        snp.CDDATA   <= beat_data(seed_reg[hit_idx], '0);
                        snp.CDLAST   <= (NB == 1);
                        seed_lat_reg <= seed_reg[hit_idx];
                        beat_reg     <= '0;
                    end
                    state_reg <= S_RESP;
                end
                S_RESP: begin
                    if (snp.CRVALID && snp.CRREADY) begin
                        snp.CRVALID <= 1'b0;
                        snp.CRRESP  <= '0;
                    end
                    if (snp.CDVALID && snp.CDREADY) begin
                        if (snp.CDLAST) begin
                            snp.CDVALID <= 1'b0;
                            snp.CDLAST  <= 1'b0;
                            snp.CDDATA  <= '0;
                        end else begin
                            beat_reg   <= beat_reg + 1'b1;
                            snp.CDDATA <= beat_data(seed_lat_reg, beat_reg + 1'b1);
                            snp.CDLAST <= ((beat_reg + 1'b1) == BEAT_W'(NB - 1));
                        end
                    end
                    if (!cr_busy && !cd_busy) begin
                        state_reg   <= S_IDLE;
                        snp.ACREADY <= 1'b1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
            // Fill is applied last so it overrides a snoop update to the same entry.
            if (fill_valid) begin
                valid_reg[fill_index]  <= fill_en;
                dirty_reg[fill_index]  <= fill_dirty;
                shared_reg[fill_index] <= fill_shared;
                tag_reg[fill_index]    <= fill_tag;
                seed_reg[fill_index]   <= fill_seed;
            end
        end
    end
endmodule

// File: tb/tb_ace_snoop_responder.sv
module tb_ace_snoop_responder;
    logic        clk = 1'b0;
    logic        ARESET;
    logic        fill_valid;
    logic [1:0]  fill_index;
    logic [57:0] fill_tag;
    logic        fill_en, fill_dirty, fill_shared;
    logic [31:0] fill_seed;
    logic [15:0] hit_count;

    ace_snoop_responder_if #(.ADDR_WIDTH(64), .SNOOP_DATA_WIDTH(128)) bus ();

    ace_snoop_responder dut (
        .ACLK        (clk),
        .ARESET      (ARESET),
        .snp         (bus),
        .fill_valid  (fill_valid),
        .fill_index  (fill_index),
        .fill_tag    (fill_tag),
        .fill_en     (fill_en),
        .fill_dirty  (fill_dirty),
        .fill_shared (fill_shared),
        .fill_seed   (fill_seed),
        .hit_count   (hit_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: line table plus queues of expected CR responses and CD beats.
    bit          m_valid  [4];
    logic [57:0] m_tag    [4];
    bit          m_dirty  [4];
    bit          m_shared [4];
    logic [31:0] m_seed   [4];
    int          m_hits;
    logic [4:0]   exp_cr [$];
    logic [127:0] exp_cd [$];
    bit           exp_last [$];

    // Observations recorded by the compare process for per-snoop literal checks.
    logic [4:0]   last_crresp;
    int           beats_seen;
    logic [127:0] first_beat, last_beat;
    int           cyc, cr_done_cyc, cd_last_cyc;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) m_valid[i] = 0;
        m_hits = 0;
        exp_cr.delete();
        exp_cd.delete();
        exp_last.delete();
    endfunction

    function automatic void model_snoop(input logic [63:0] addr, input logic [3:0] op);
        int idx = -1;
        bit d, s, dt, pd, is_sh;
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            if (idx < 0 && m_valid[i] && m_tag[i] == addr[63:6]) idx = i;
        if (idx < 0 || !(op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13})) begin
            exp_cr.push_back(5'h00);
            return;
        end
        d = m_dirty[idx];
        s = m_shared[idx];
        dt = 1; pd = d; is_sh = 1;
        if (op == 0) pd = 0;
        else if (op inside {4'd1, 4'd2, 4'd3}) begin m_shared[idx] = 1; m_dirty[idx] = 0; end
        else if (op == 7) begin is_sh = 0; m_valid[idx] = 0; end
        else if (op == 9) begin dt = d; is_sh = 0; m_valid[idx] = 0; end
        else if (op == 8) begin dt = d; m_dirty[idx] = 0; end
        else begin dt = 0; pd = 0; is_sh = 0; m_valid[idx] = 0; end
        if (m_hits < 65535) m_hits++;
        exp_cr.push_back({!s, is_sh, pd, 1'b0, dt});
        if (dt)
            for (int k = 0; k < 4; k++) begin
                w = m_seed[idx] + k;
                exp_cd.push_back({4{w}});
                exp_last.push_back(k == 3);
            end
    endfunction

    // Compare process: every cycle a valid is up, its payload must match the queue head.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (!ARESET) begin
                if (bus.CRVALID) begin
                    if (exp_cr.size() == 0) check("cr_unexpected", bus.CRVALID, 0);
                    else begin
                        check("crresp", bus.CRRESP, exp_cr[0]);
                        if (bus.CRREADY) begin
                            last_crresp = bus.CRRESP;
                            cr_done_cyc = cyc;
                            void'(exp_cr.pop_front());
                        end
                    end
                end
                if (bus.CDVALID) begin
                    if (exp_cd.size() == 0) check("cd_unexpected", bus.CDVALID, 0);
                    else begin
                        check("cddata", bus.CDDATA, exp_cd[0]);
                        check("cdlast", bus.CDLAST, exp_last[0]);
                        if (bus.CDREADY) begin
                            if (beats_seen == 0) first_beat = bus.CDDATA;
                            last_beat = bus.CDDATA;
                            beats_seen++;
                            if (bus.CDLAST) cd_last_cyc = cyc;
                            void'(exp_cd.pop_front());
                            void'(exp_last.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic do_fill(input logic [1:0] idx, input logic [57:0] tag, input bit en,
                           input bit dirty, input bit shared, input logic [31:0] seed);
        @(negedge clk);
        fill_valid = 1; fill_index = idx; fill_tag = tag;
        fill_en = en; fill_dirty = dirty; fill_shared = shared; fill_seed = seed;
        m_valid[idx] = en; m_tag[idx] = tag; m_dirty[idx] = dirty;
        m_shared[idx] = shared; m_seed[idx] = seed;
        @(negedge clk);
        fill_valid = 0;
    endtask

    // exp_edges: hand-computed edges from AC handshake to ACREADY high again.
    // reset_at: if nonzero, ARESET is pulsed at that negedge after the handshake.
    task automatic do_snoop(input logic [63:0] addr, input logic [3:0] op, input int cr_stall,
                            input int cd_stall, input int exp_edges, input int reset_at);
        int got = -1;
        int waited = 0;
        beats_seen = 0;
        cr_done_cyc = 0;
        cd_last_cyc = 0;
        last_crresp = 5'h1F;
        @(negedge clk);
        while (!bus.ACREADY && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("acready_wait", bus.ACREADY, 1);
        bus.ACVALID = 1; bus.ACADDR = addr; bus.ACSNOOP = op;
        @(posedge clk);
        model_snoop(addr, op);
        for (int k = 1; k <= 60 && got < 0; k++) begin
            @(negedge clk);
            bus.ACVALID = 0;
            bus.CRREADY = (k >= 2 + cr_stall);
            bus.CDREADY = (k >= 2 + cd_stall);
            if (reset_at == k) begin
                ARESET = 1;
                #1;
                check("rst_cdvalid", bus.CDVALID, 0);
                check("rst_crvalid", bus.CRVALID, 0);
                check("rst_cddata", bus.CDDATA, 0);
                check("rst_acready", bus.ACREADY, 0);
                model_clear();
                bus.CRREADY = 0; bus.CDREADY = 0;
                @(negedge clk);
                ARESET = 0;
                #1 check("acready_at_release", bus.ACREADY, 0);
                @(negedge clk);
                #1 check("acready_after_release", bus.ACREADY, 1);
                check("hit_count_after_rst", hit_count, 0);
                return;
            end
            #1;
            if (bus.ACREADY) got = k - 1;
        end
        bus.CRREADY = 0; bus.CDREADY = 0;
        $display("snoop addr=%h op=%h crresp=%h beats=%0d edges=%0d", addr, op, last_crresp,
                 beats_seen, got);
        check("return_edges", got, exp_edges);
        check("cr_drained", exp_cr.size(), 0);
        check("cd_drained", exp_cd.size(), 0);
        check("hit_count", hit_count, m_hits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1;
        fill_valid = 0; fill_index = 0; fill_tag = 0; fill_en = 0;
        fill_dirty = 0; fill_shared = 0; fill_seed = 0;
        bus.ACVALID = 0; bus.ACADDR = 0; bus.ACSNOOP = 0; bus.ACPROT = 0;
        bus.CRREADY = 0; bus.CDREADY = 0;
        model_clear();
        repeat (3) @(negedge clk);
        #1;
        check("reset_acready", bus.ACREADY, 0);
        check("reset_crvalid", bus.CRVALID, 0);
        check("reset_crresp", bus.CRRESP, 0);
        check("reset_cdvalid", bus.CDVALID, 0);
        check("reset_cddata", bus.CDDATA, 0);
        check("reset_cdlast", bus.CDLAST, 0);
        check("reset_hit_count", hit_count, 0);
        @(negedge clk);
        ARESET = 0;
        #1 check("acready_before_edge", bus.ACREADY, 0);
        @(negedge clk);
        #1 check("acready_after_edge", bus.ACREADY, 1);

        // Dirty unique line, ReadShared: full burst, then line becomes shared clean.
        do_fill(0, 58'h40, 1, 1, 0, 32'h100);
        do_snoop(64'h1000, 4'h1, 0, 0, 5, 0);
        check("lit_rs1_resp", last_crresp, 5'h1D);
        check("lit_rs1_beats", beats_seen, 4);
        check("lit_rs1_beat0", first_beat, {4{32'h100}});
        check("lit_rs1_beat3", last_beat, {4{32'h103}});
        do_snoop(64'h1000, 4'h1, 0, 0, 5, 0);
        check("lit_rs2_resp", last_crresp, 5'h09);

        // Miss with ReadUnique: no data, back to idle two edges after handshake.
        do_snoop(64'h2000, 4'h7, 0, 0, 2, 0);
        check("lit_miss_resp", last_crresp, 5'h00);
        check("lit_miss_beats", beats_seen, 0);

        // CD stalled five cycles: CR finishes first, idle only after the last beat.
        do_snoop(64'h1000, 4'h1, 0, 5, 10, 0);
        check("lit_stall_resp", last_crresp, 5'h09);
        check("lit_stall_beats", beats_seen, 4);
        check("lit_cr_before_cd", cr_done_cyc < cd_last_cyc, 1);

        // MakeInvalid on a clean unique line, then the line misses.
        do_fill(1, 58'h100, 1, 0, 0, 32'h200);
        do_snoop(64'h4000, 4'hD, 0, 0, 2, 0);
        check("lit_mi_resp", last_crresp, 5'h10);
        check("lit_mi_beats", beats_seen, 0);
        do_snoop(64'h4000, 4'h0, 0, 0, 2, 0);
        check("lit_ro_miss_resp", last_crresp, 5'h00);
        check("lit_hits4", hit_count, 16'd4);

        // CleanInvalid on a dirty shared line: data passed, line dropped.
        do_fill(3, 58'h140, 1, 1, 1, 32'h500);
        do_snoop(64'h5000, 4'h9, 0, 0, 5, 0);
        check("lit_ci_resp", last_crresp, 5'h05);
        check("lit_ci_beat0", first_beat, {4{32'h500}});
        do_snoop(64'h5000, 4'h8, 0, 0, 2, 0);
        check("lit_cs_miss_resp", last_crresp, 5'h00);

        // Reset during beat 2 of a ReadOnce burst; afterwards the table is empty.
        do_fill(2, 58'hC0, 1, 0, 0, 32'h300);
        do_snoop(64'h3000, 4'h0, 0, 0, 0, 4);
        do_snoop(64'h3000, 4'h0, 0, 0, 2, 0);
        check("lit_post_rst_resp", last_crresp, 5'h00);
        do_snoop(64'h1000, 4'h1, 0, 0, 2, 0);
        check("lit_post_rst_resp2", last_crresp, 5'h00);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ace_snoop_responder.md
# ace_snoop_responder

Master-side snoop responder that terminates the ACE snoop channels driven by the ACE slave VIP. It accepts AC requests, looks up a small fully-associative line-state table, and returns a CR response. When the response carries data, it also returns a CD data burst. The table is preloaded through a fill port, so each bench controls which lines hit and in what state.

## Interface
- ADDR_WIDTH, 64, width of ACADDR
- SNOOP_DATA_WIDTH, 128, CDDATA width; must be a multiple of 32
- CACHE_LINE_SIZE, 6, log2 of line size in bytes
- DEPTH, 4, number of table entries
- ACLK  in  1  clock; all logic is rising-edge
- ARESET  in  1  asynchronous reset, active-high
- ACVALID / ACREADY  in / out  1 / 1  snoop address handshake
- ACADDR  in  ADDR_WIDTH  snoop address
- ACSNOOP  in  4  snoop opcode
- ACPROT  in  3  ignored
- CRVALID / CRREADY  out / in  1 / 1  snoop response handshake
- CRRESP  out  5  response bits: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique
- CDVALID / CDREADY  out / in  1 / 1  snoop data handshake
- CDDATA  out  SNOOP_DATA_WIDTH  snoop data beat
- CDLAST  out  1  final data beat
- fill_valid  in  1  table write strobe
- fill_index  in  clog2(DEPTH)  entry to write
- fill_tag  in  ADDR_WIDTH-CACHE_LINE_SIZE  line tag
- fill_en, fill_dirty, fill_shared  in  1 each  entry valid, dirty and shared bits
- fill_seed  in  32  data seed for the entry
- hit_count  out  16  saturating count of snoop hits

## Operation
- Tag is ACADDR[ADDR_WIDTH-1:CACHE_LINE_SIZE].
- A hit is an entry that is valid and whose tag matches. If several entries match, the lowest index wins.
- Data beat k carries {fill_seed+k} replicated SNOOP_DATA_WIDTH/32 times.
- Burst length is NB = 2^CACHE_LINE_SIZE / (SNOOP_DATA_WIDTH/8) beats, with a minimum of 1. With the defaults, NB = 4.
- Miss, or any unlisted opcode: CRRESP = 0, no data, table unchanged.
- Hit, ReadOnce (0000): DT=1, IsShared=1, WasUnique=!shared, PassDirty=0. State unchanged.
- Hit, ReadShared/ReadClean/ReadNotSharedDirty (0001/0010/0011): DT=1, IsShared=1, PassDirty=dirty, WasUnique=!shared. New state: shared=1, dirty=0.
- Hit, ReadUnique (0111): DT=1, PassDirty=dirty, WasUnique=!shared, IsShared=0. Entry invalidated.
- Hit, CleanInvalid (1001): DT=dirty, PassDirty=dirty, WasUnique=!shared, IsShared=0. Entry invalidated.
- Hit, CleanShared (1000): DT=dirty, PassDirty=dirty, IsShared=1, WasUnique=!shared. dirty cleared.
- Hit, MakeInvalid (1101): CRRESP = {WasUnique=!shared, 0, 0, 0, 0}. Entry invalidated.
- Error is never set.
- hit_count increments once per hit and saturates at 0xFFFF.

## Timing
- Reset values: ACREADY=0, CRVALID=0, CRRESP=0, CDVALID=0, CDDATA=0, CDLAST=0, hit_count=0, all entries invalid. State is IDLE.
- ACREADY rises on the first ACLK edge after ARESET deasserts. It is registered and high only in IDLE.
- State machine:
  - IDLE -> LOOKUP on the AC handshake (edge T). ACREADY drops at T.
  - LOOKUP -> RESP at T+1. Table update, hit_count update and latching of the seed and response all happen at this edge.
  - At T+1, CRVALID=1 with CRRESP valid. If DT=1, CDVALID=1 in the same cycle with beat 0.
  - CRVALID and CRRESP are held until CRREADY. CDVALID and CDDATA are held until CDREADY.
  - CD advances one beat per CDREADY. CDLAST is high only on beat NB-1.
  - The CR and CD channels complete independently, in either order.
  - RESP -> IDLE on the edge where the last outstanding handshake (CR, or CR plus the final CD beat) completes. ACREADY=1 in that same edge.
- Minimum AC-to-AC spacing is 3 cycles (CRREADY=CDREADY=1 and NB=1).
- A fill on the LOOKUP edge to the entry being updated by the snoop: the fill wins.
- A fill during RESP to the snooped entry does not alter the in-flight response or data, because they were latched at LOOKUP.
- A fill and a lookup on the same edge: the lookup uses the pre-fill contents.
- ARESET mid-burst: all outputs return to their reset values immediately and the table is cleared. No partial burst resumes.

## Test plan
- Reset then idle: ACREADY=0 while ARESET=1. ACREADY=1 one edge after release. All other outputs 0.
- Fill entry 0 {tag=0x40, dirty=1, shared=0, seed=0x100}, then ReadShared to ACADDR=0x1000 -> CRRESP=0x1D. CD data 0x100..0x103 (each replicated) over 4 beats, CDLAST on beat 3. A repeat ReadShared -> CRRESP=0x09.
- Miss on ACADDR=0x2000 with ReadUnique -> CRRESP=0x00, CDVALID stays 0, ACREADY back high 2 edges after the AC handshake.
- CDREADY held low for 5 cycles, CRREADY immediate -> CR completes first. CDVALID is held with beat 0 stable. IDLE is reached only after the beat-3 handshake.
- MakeInvalid on a clean unique line (shared=0, dirty=0) -> CRRESP=0x10, no data. A following ReadOnce to the same line -> CRRESP=0x00 (miss).
- ARESET pulse during beat 2 of a burst -> CDVALID=0 and CRVALID=0 immediately. The next snoop misses because the table was cleared.
